// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
package imem_dmem_arbiter_pkg;

    // Bus widths shared with the CPU top.
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE_IF = 2'd1,
        ISSUE_DM = 2'd2,
        RESP     = 2'd3
    } state_t;

    // Which requester owns the current access.
    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_DM = 1'b1
    } grant_t;

endpackage : imem_dmem_arbiter_pkg

// File: rtl/imem_dmem_arbiter_arb_priority_sel.sv
// Combinational priority select (arb_priority_sel): data normally beats fetch,
// but a waiting fetch wins once the data streak reaches its limit.
module imem_dmem_arbiter_arb_priority_sel
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int DM_STREAK_MAX = 4,
    parameter int STREAK_W      = 3
) (
    input  logic                if_req,
    input  logic                dm_req,
    input  logic [STREAK_W-1:0] streak,
    output grant_t              grant,
    output logic [STREAK_W-1:0] streak_next
);

    localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(DM_STREAK_MAX);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

    // Choose the winner and the streak value to keep after this grant.
    always_comb begin
        grant       = GRANT_IF;
        streak_next = '0;
        if (dm_req && (!if_req || (streak < STREAK_LIM))) begin
            grant = GRANT_DM;
            if (if_req) begin
                // Saturate so a stalled fetch always gets the next slot.
                if (streak < STREAK_LIM) begin
                    streak_next = streak + STREAK_ONE;
                end else begin
                    streak_next = STREAK_LIM;
                end
            end else begin
                streak_next = '0;
            end
        end else begin
            grant       = GRANT_IF;
            streak_next = '0;
        end
    end

endmodule : imem_dmem_arbiter_arb_priority_sel

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and data
// access. Each access runs IDLE -> ISSUE_x -> RESP -> IDLE.
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int MEM_AW        = 11,
    parameter int DM_STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ready,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              cpu_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int STREAK_W = $clog2(DM_STREAK_MAX + 1);

    state_t              state_r, state_s;
    grant_t              grant_s;
    logic [STREAK_W-1:0] streak_r, streak_next_s;
    logic                arb_fire_s;
    logic [ADDR_W-1:0]   addr_sel_s;
    logic                dm_wr_r;
    logic                mem_en_r, mem_we_r;
    logic [MEM_AW-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic                if_ready_r, dm_ready_r;
    logic [DATA_W-1:0]   if_rdata_r, dm_rdata_r;
    logic                unused_addr_bits_s;

    imem_dmem_arbiter_arb_priority_sel #(
        .DM_STREAK_MAX (DM_STREAK_MAX),
        .STREAK_W      (STREAK_W)
    ) u_prio (
        .if_req      (if_req),
        .dm_req      (dm_req),
        .streak      (streak_r),
        .grant       (grant_s),
        .streak_next (streak_next_s)
    );

    assign arb_fire_s = (state_r == IDLE) && (if_req || dm_req);
    assign addr_sel_s = (grant_s == GRANT_DM) ? dm_addr : if_addr;

    // Byte-offset and above-RAM address bits are deliberately dropped (wrap).
    assign unused_addr_bits_s = ^{if_addr[1:0], dm_addr[1:0],
                                  if_addr[ADDR_W-1:MEM_AW+2], dm_addr[ADDR_W-1:MEM_AW+2]};

    // Next-state decode; requests are only looked at in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (arb_fire_s) begin
                    state_s = (grant_s == GRANT_DM) ? ISSUE_DM : ISSUE_IF;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE_IF: state_s = RESP;
            ISSUE_DM: state_s = RESP;
            RESP:     state_s = IDLE;
            default:  state_s = IDLE;
        endcase
    end

    // State, arbitration bookkeeping, RAM command and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            streak_r    <= '0;
            dm_wr_r     <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            if_ready_r  <= 1'b0;
            dm_ready_r  <= 1'b0;
            if_rdata_r  <= '0;
            dm_rdata_r  <= '0;
        end else begin
            state_r <= state_s;
            if (arb_fire_s) begin
                // Latch the winner's command so a dropped request still completes.
                streak_r    <= streak_next_s;
                dm_wr_r     <= (grant_s == GRANT_DM) && dm_we;
                mem_en_r    <= 1'b1;
                mem_we_r    <= (grant_s == GRANT_DM) && dm_we;
                mem_addr_r  <= addr_sel_s[MEM_AW+1:2];
                mem_wdata_r <= (grant_s == GRANT_DM) ? dm_wdata : '0;
            end else begin
                mem_en_r    <= 1'b0;
                mem_we_r    <= 1'b0;
                mem_addr_r  <= '0;
                mem_wdata_r <= '0;
            end
            if_ready_r <= (state_r == ISSUE_IF);
            dm_ready_r <= (state_r == ISSUE_DM);
            if (if_ready_r) begin
                if_rdata_r <= mem_rdata;
            end
            if (dm_ready_r && !dm_wr_r) begin
                dm_rdata_r <= mem_rdata;
            end
        end
    end

    // RAM data arrives in RESP, so it is forwarded during the ready pulse and
    // held in the response register afterwards.
    assign if_rdata  = if_ready_r ? mem_rdata : if_rdata_r;
    assign dm_rdata  = (dm_ready_r && !dm_wr_r) ? mem_rdata : dm_rdata_r;
    assign if_ready  = if_ready_r;
    assign dm_ready  = dm_ready_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign cpu_stall = (if_req && !if_ready_r) || (dm_req && !dm_ready_r);

endmodule : imem_dmem_arbiter
